// File: rtl/bubble_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bubble_pkg
// Description : Shared constants and state encoding for the SPI page loader.
// Revision    : 1.0 - initial release
// ============================================================================
package bubble_pkg;

    localparam logic [7:0]  SPI_CMD_READ = 8'h03;
    localparam logic [11:0] BOOT_PAGE    = 12'h805;
    localparam int          PAGE_ENTRIES = 512;
    localparam int          BOOT_ENTRIES = 2048;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        ADDR = 3'd2,
        DATA = 3'd3,
        DONE = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/spi_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : spi_shift_engine
// Description : SPI mode-0 clock divider with rise/fall bit strobes and MISO sampling.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_shift_engine #(
    parameter int SCLK_HALF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    input  logic i_clear,
    input  logic i_hold,
    input  logic i_miso,
    output logic o_sclk,
    output logic o_bit_tick_rise,
    output logic o_bit_tick_fall,
    output logic o_rx_bit,
    output logic o_rx_valid
);

    logic [3:0] cnt_q, cnt_d;
    logic       sclk_q, sclk_d;
    logic       rx_bit_q, rx_bit_d;
    logic       rx_valid_q, rx_valid_d;
    logic       w_half_end;

    assign w_half_end      = (cnt_q == 4'(SCLK_HALF - 1));
    assign o_bit_tick_rise = i_run && !sclk_q && !i_hold && w_half_end;
    assign o_bit_tick_fall = i_run && sclk_q && w_half_end;

    // Strobes never depend on i_clear, so the caller may derive i_clear from its next state.
    always_comb begin
        cnt_d      = cnt_q;
        sclk_d     = sclk_q;
        rx_bit_d   = o_bit_tick_rise ? i_miso : rx_bit_q;
        rx_valid_d = o_bit_tick_rise;
        if (!i_run || i_clear || (!sclk_q && i_hold)) begin
            cnt_d  = 4'd0;
            sclk_d = 1'b0;
        end else if (w_half_end) begin
            cnt_d  = 4'd0;
            sclk_d = ~sclk_q;
        end else begin
            cnt_d  = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= 4'd0;
            sclk_q     <= 1'b0;
            rx_bit_q   <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sclk_q     <= sclk_d;
            rx_bit_q   <= rx_bit_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign o_sclk     = sclk_q;
    assign o_rx_bit   = rx_bit_q;
    assign o_rx_valid = rx_valid_q;

endmodule
`default_nettype wire

// File: rtl/spi_page_loader.sv
`default_nettype none
// ============================================================================
// Module      : spi_page_loader
// Description : Fetches a page or bootloader block from SPI NOR flash and unpacks
//               it into 2-bit entries of the bubble output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_page_loader
    import bubble_pkg::*;
#(
    parameter int          SCLK_HALF    = 2,
    parameter int          PAGE_ENTRIES = bubble_pkg::PAGE_ENTRIES,
    parameter int          BOOT_ENTRIES = bubble_pkg::BOOT_ENTRIES,
    parameter logic [11:0] BOOT_PAGE    = bubble_pkg::BOOT_PAGE
) (
    input  logic        master_clock,
    input  logic        reset,
    input  logic [2:0]  image_number,
    input  logic [21:0] start_of_page_address,
    input  logic        load_page,
    input  logic        load_bootloader,
    output logic [10:0] bubble_buffer_write_address,
    output logic [1:0]  bubble_buffer_data_input,
    output logic        bubble_buffer_write_enable,
    output logic        bubble_buffer_write_clock,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        busy,
    output logic        done
);

    state_e      state_q, state_n;
    logic        prev_page_q, prev_page_d, prev_boot_q, prev_boot_d;
    logic        boot_q, boot_d;
    logic [30:0] tx_q, tx_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [12:0] rx_cnt_q, rx_cnt_d;
    logic [11:0] tgt_q, tgt_d;
    logic        pair_q, pair_d, first_q, first_d;
    logic [10:0] addr_q, addr_d;
    logic [1:0]  data_q, data_d;
    logic        we_n_q, we_n_d, cs_n_q, cs_n_d, mosi_q, mosi_d;
    logic        busy_q, busy_d, done_q, done_d;

    logic        w_trig_page, w_trig_boot, w_abort, w_last, w_hold;
    logic        w_run, w_clear, w_rise, w_fall, w_rx_bit, w_rx_valid;
    logic [23:0] w_flash_addr;

    assign w_trig_page  = prev_page_q & ~load_page;
    assign w_trig_boot  = prev_boot_q & ~load_bootloader;
    assign w_abort      = boot_q ? load_bootloader : load_page;
    assign w_last       = ({1'b0, addr_q} == (tgt_q - 12'd1));
    assign w_hold       = (state_q == DATA) && (rx_cnt_q == {tgt_q, 1'b0});
    assign w_run        = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);
    assign w_clear      = !((state_n == CMD) || (state_n == ADDR) || (state_n == DATA));
    assign w_flash_addr = w_trig_boot ? {2'b00, image_number, BOOT_PAGE, 7'b0}
                                      : {2'b00, start_of_page_address};

    spi_shift_engine #(.SCLK_HALF(SCLK_HALF)) u_engine (
        .clk             (master_clock),
        .rst             (reset),
        .i_run           (w_run),
        .i_clear         (w_clear),
        .i_hold          (w_hold),
        .i_miso          (spi_miso),
        .o_sclk          (spi_sclk),
        .o_bit_tick_rise (w_rise),
        .o_bit_tick_fall (w_fall),
        .o_rx_bit        (w_rx_bit),
        .o_rx_valid      (w_rx_valid)
    );

    always_ff @(posedge master_clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE: if (w_trig_page || w_trig_boot)      state_n = CMD;
            CMD:  if (w_abort)                         state_n = IDLE;
                  else if (w_fall && bit_cnt_q == 5'd7) state_n = ADDR;
            ADDR: if (w_abort)                          state_n = IDLE;
                  else if (w_fall && bit_cnt_q == 5'd31) state_n = DATA;
            DATA: if (w_abort)                          state_n = IDLE;
                  else if (!we_n_q && w_last)           state_n = DONE;
            DONE:                                       state_n = IDLE;
            default:                                    state_n = IDLE;
        endcase
    end

    // Registered outputs follow the next state, so cs_n/busy/done change with the state itself.
    always_comb begin
        prev_page_d = load_page;
        prev_boot_d = load_bootloader;
        boot_d      = boot_q;
        tx_d        = tx_q;
        bit_cnt_d   = bit_cnt_q;
        rx_cnt_d    = rx_cnt_q;
        tgt_d       = tgt_q;
        pair_d      = pair_q;
        first_d     = first_q;
        addr_d      = addr_q;
        data_d      = data_q;
        mosi_d      = mosi_q;
        we_n_d      = 1'b1;
        cs_n_d      = w_clear;
        busy_d      = (state_n != IDLE);
        done_d      = (state_n == DONE);
        case (state_q)
            IDLE: if (w_trig_page || w_trig_boot) begin
                boot_d    = w_trig_boot;
                tx_d      = {SPI_CMD_READ[6:0], w_flash_addr};
                mosi_d    = SPI_CMD_READ[7];
                tgt_d     = w_trig_boot ? 12'(BOOT_ENTRIES) : 12'(PAGE_ENTRIES);
                addr_d    = 11'd0;
                bit_cnt_d = 5'd0;
                rx_cnt_d  = 13'd0;
                pair_d    = 1'b0;
            end
            CMD, ADDR: if (w_fall) begin
                bit_cnt_d = bit_cnt_q + 5'd1;
                mosi_d    = tx_q[30];
                tx_d      = {tx_q[29:0], 1'b0};
            end
            DATA: begin
                if (w_rise) rx_cnt_d = rx_cnt_q + 13'd1;
                if (w_rx_valid) begin
                    if (!pair_q) begin
                        first_d = w_rx_bit;
                        pair_d  = 1'b1;
                    end else begin
                        data_d  = {first_q, w_rx_bit};
                        we_n_d  = (state_n != DATA);
                        pair_d  = 1'b0;
                    end
                end
                if (!we_n_q && !w_last) addr_d = addr_q + 11'd1;
            end
            default: ;
        endcase
        if (w_clear) mosi_d = 1'b0;
    end

    always_ff @(posedge master_clock) begin
        if (reset) begin
            prev_page_q <= 1'b1;
            prev_boot_q <= 1'b1;
            boot_q      <= 1'b0;
            tx_q        <= 31'd0;
            bit_cnt_q   <= 5'd0;
            rx_cnt_q    <= 13'd0;
            tgt_q       <= 12'd0;
            pair_q      <= 1'b0;
            first_q     <= 1'b0;
            addr_q      <= 11'd0;
            data_q      <= 2'd0;
            mosi_q      <= 1'b0;
            we_n_q      <= 1'b1;
            cs_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            prev_page_q <= prev_page_d;
            prev_boot_q <= prev_boot_d;
            boot_q      <= boot_d;
            tx_q        <= tx_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            tgt_q       <= tgt_d;
            pair_q      <= pair_d;
            first_q     <= first_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            mosi_q      <= mosi_d;
            we_n_q      <= we_n_d;
            cs_n_q      <= cs_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bubble_buffer_write_address = addr_q;
    assign bubble_buffer_data_input    = data_q;
    assign bubble_buffer_write_enable  = we_n_q;
    assign bubble_buffer_write_clock   = master_clock;
    assign spi_cs_n                    = cs_n_q;
    assign spi_mosi                    = mosi_q;
    assign busy                        = busy_q;
    assign done                        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_page_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_page_loader
// Description : Self-checking bench with a behavioural SPI flash and buffer scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_page_loader;

    localparam int SCLK_HALF = 2;
    localparam int BUDGET    = 30000;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  image_number;
    logic [21:0] sopa;
    logic        load_page, load_boot;
    logic [10:0] wr_addr;
    logic [1:0]  wr_data;
    logic        we_n, wclk, cs_n, sclk, mosi, busy, done;
    logic        miso = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    spi_page_loader #(.SCLK_HALF(SCLK_HALF)) dut (
        .master_clock                (clk),
        .reset                       (rst),
        .image_number                (image_number),
        .start_of_page_address       (sopa),
        .load_page                   (load_page),
        .load_bootloader             (load_boot),
        .bubble_buffer_write_address (wr_addr),
        .bubble_buffer_data_input    (wr_data),
        .bubble_buffer_write_enable  (we_n),
        .bubble_buffer_write_clock   (wclk),
        .spi_cs_n                    (cs_n),
        .spi_sclk                    (sclk),
        .spi_mosi                    (mosi),
        .spi_miso                    (miso),
        .busy                        (busy),
        .done                        (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flash contents returned after the 32 command/address bits.
    logic [7:0]  rom [512];
    logic [10:0] wq_addr [$];
    logic [1:0]  wq_data [$];
    logic [31:0] cap = 32'd0;
    int bit_idx = 0, done_cnt = 0, dbl_cnt = 0, cyc = 0, fall_cyc = 0, rise_cyc = 0;
    logic sclk_prev = 1'b0, cs_prev = 1'b1, we_prev = 1'b1;

    function automatic logic rom_bit(input int k);
        logic [7:0] b;
        b = rom[(k / 8) % 512];
        return b[7 - (k % 8)];
    endfunction

    function automatic logic [1:0] exp_entry(input int i);
        return 2'((rom[i / 4] >> (6 - 2 * (i % 4))) & 8'd3);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cs_n) begin
            bit_idx = 0;
            miso    = 1'b0;
        end else if (sclk && !sclk_prev) begin
            if (bit_idx == 0) rise_cyc = cyc;
            if (bit_idx < 32) cap = {cap[30:0], mosi};
            bit_idx++;
            if (bit_idx >= 32) miso = rom_bit(bit_idx - 32);
        end
        if (cs_prev && !cs_n) fall_cyc = cyc;
        if (!we_n) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
            if (!we_prev) dbl_cnt++;
        end
        if (done) done_cnt++;
        sclk_prev = sclk;
        cs_prev   = cs_n;
        we_prev   = we_n;
    end

    task automatic fill_rom();
        for (int i = 0; i < 512; i++) rom[i] = 8'($urandom);
    endtask

    task automatic start_fetch(input bit pg, input bit bt);
        wq_addr.delete();
        wq_data.delete();
        done_cnt = 0;
        dbl_cnt  = 0;
        @(negedge clk);
        if (pg) load_page = 1'b0;
        if (bt) load_boot = 1'b0;
        @(negedge clk);
        check("start_busy_csn", {30'd0, busy, cs_n}, 32'b10);
    endtask

    task automatic finish_fetch(input logic [23:0] exp_addr, input int n);
        int k = 0;
        while (done_cnt == 0 && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", 32'(done_cnt != 0), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("end_busy_csn_sclk", {29'd0, busy, cs_n, sclk}, 32'b010);
        check("cmd_addr", cap, {8'h03, exp_addr});
        check("first_rise", 32'(rise_cyc - fall_cyc), 32'(SCLK_HALF));
        check("n_writes", 32'(wq_addr.size()), 32'(n));
        check("done_cnt", 32'(done_cnt), 32'd1);
        check("dbl_strobe", 32'(dbl_cnt), 32'd0);
        if (wq_addr.size() > 0) check("last_addr", 32'(wq_addr[$]), 32'(n - 1));
        for (int i = 0; i < wq_addr.size() && i < n; i++)
            check("entry", {19'd0, wq_addr[i], wq_data[i]}, {19'd0, 11'(i), exp_entry(i)});
        load_page = 1'b1;
        load_boot = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [2:0]  img;
        logic [21:0] pa;
        int          k;

        rst          = 1'b1;
        load_page    = 1'b1;
        load_boot    = 1'b1;
        image_number = 3'd0;
        sopa         = 22'd0;
        repeat (3) @(negedge clk);
        check("reset_vals", {14'd0, cs_n, sclk, mosi, we_n, busy, done, wr_addr, wr_data},
              {14'd0, 6'b100100, 11'd0, 2'd0});
        check("wclk_pass", {31'd0, wclk}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle", {27'd0, cs_n, sclk, we_n, busy, done}, {27'd0, 5'b10100});
        end

        // Page fetch with a known leading pattern
        fill_rom();
        rom[0] = 8'h1B;
        rom[1] = 8'hE4;
        sopa = 22'h0ABC80;
        start_fetch(1'b1, 1'b0);
        finish_fetch(24'h0ABC80, 512);

        // Bootloader fetch for image 5
        fill_rom();
        image_number = 3'd5;
        start_fetch(1'b0, 1'b1);
        finish_fetch(24'h2C0280, 2048);

        // Simultaneous triggers: bootloader takes priority
        fill_rom();
        img = 3'($urandom);
        pa  = {15'($urandom), 7'd0};
        image_number = img;
        sopa = pa;
        start_fetch(1'b1, 1'b1);
        finish_fetch({2'b00, img, 12'h805, 7'd0}, 2048);

        // Abort after 100 entries, then a fresh fetch
        fill_rom();
        sopa = {15'($urandom), 7'd0};
        start_fetch(1'b1, 1'b0);
        k = 0;
        while (wq_addr.size() < 100 && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        load_page = 1'b1;
        @(negedge clk);
        check("abort_csn", {31'd0, cs_n}, 32'd1);
        repeat (60) @(negedge clk);
        check("abort_writes", 32'(wq_addr.size()), 32'd100);
        if (wq_addr.size() > 0) check("abort_last", 32'(wq_addr[$]), 32'd99);
        check("abort_done", 32'(done_cnt), 32'd0);
        check("abort_idle", {29'd0, busy, sclk, we_n}, 32'b001);
        pa = {15'($urandom), 7'd0};
        sopa = pa;
        start_fetch(1'b1, 1'b0);
        finish_fetch({2'b00, pa}, 512);

        // Reset in the middle of the address phase, then a normal fetch
        fill_rom();
        start_fetch(1'b1, 1'b0);
        k = 0;
        while (bit_idx < 14 && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        rst = 1'b1;
        @(negedge clk);
        check("midreset_vals", {14'd0, cs_n, sclk, mosi, we_n, busy, done, wr_addr, wr_data},
              {14'd0, 6'b100100, 11'd0, 2'd0});
        rst = 1'b0;
        load_page = 1'b1;
        repeat (3) @(negedge clk);
        fill_rom();
        pa = {15'($urandom), 7'd0};
        sopa = pa;
        start_fetch(1'b1, 1'b0);
        finish_fetch({2'b00, pa}, 512);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_page_loader.md
Name: spi_page_loader

Overview:
- Upstream feeder of the bubble output stage.
- On a falling edge of load_page or load_bootloader, it fetches one page or the bootloader block from SPI NOR flash (READ 0x03, SPI mode 0).
- It unpacks each fetched byte into 2-bit odd/even entries and writes them into the bubble output buffer through its write port: address, data, active-low enable, clock.
- It drives the flash chip select, clock and MOSI, and samples MISO.

Parameters:
- SCLK_HALF, 2, master_clock cycles per SPI clock half-period (range 1..15; default gives 12 MHz SCLK at 48 MHz).
- PAGE_ENTRIES, 512, buffer entries per page fetch (128 bytes).
- BOOT_ENTRIES, 2048, buffer entries per bootloader fetch (512 bytes, pages 0x805-0x808).
- BOOT_PAGE, 12'h805, first flash page of the bootloader block.

Ports:
- master_clock  in  1  48 MHz master clock; all logic on posedge.
- reset  in  1  synchronous reset, active high.
- image_number  in  3  image select; used to form the bootloader address.
- start_of_page_address  in  22  page flash address {image, page, 7'b0}; valid while load_page is low.
- load_page  in  1  active low; falling edge starts a page fetch.
- load_bootloader  in  1  active low; falling edge starts a bootloader fetch.
- bubble_buffer_write_address  out  11  buffer entry address.
- bubble_buffer_data_input  out  2  entry data: [1] odd, [0] even.
- bubble_buffer_write_enable  out  1  active low, one-cycle write strobe.
- bubble_buffer_write_clock  out  1  equals master_clock (pass-through).
- spi_cs_n  out  1  flash chip select, active low.
- spi_sclk  out  1  flash clock; idles low.
- spi_mosi  out  1  flash data in.
- spi_miso  in  1  flash data out (already synchronised off-chip domain is not required: sampled directly on the master_clock rising edge that raises sclk).
- busy  out  1  high from trigger until return to IDLE.
- done  out  1  one-cycle pulse when the final entry is written.

Behaviour:
- Reset values: spi_cs_n=1, spi_sclk=0, spi_mosi=0, write_enable=1, write_address=0, data=0, busy=0, done=0, state IDLE. Previous-level registers of load_page and load_bootloader reset to 1.
- Triggers:
  - Edge detect uses the registered previous level; a trigger is prev=1, now=0.
  - The trigger is acted on in IDLE only. Triggers in other states are ignored, except for abort.
  - If both triggers fire in the same cycle, bootloader wins.
- Address latched at trigger:
  - Page: {2'b00, start_of_page_address}.
  - Bootloader: {2'b00, image_number, BOOT_PAGE, 7'b0}.
  - Entry target latched as PAGE_ENTRIES or BOOT_ENTRIES.
  - write_address cleared to 0.
- States:
  - IDLE -> CMD on trigger: cs_n low in the same cycle as the state change; busy=1.
  - CMD: 8 bits of 0x03, MSB first.
  - ADDR: 24 bits, MSB first.
  - DATA: receive until the entry count reaches target.
  - DONE: cs_n=1, sclk=0, done=1 for one cycle -> IDLE (busy=0).
- SPI timing:
  - Each bit = 2*SCLK_HALF cycles: sclk low half, then high half.
  - MOSI is set at the start of the low half.
  - MISO is sampled on the cycle sclk rises.
  - MOSI=0 during DATA.
  - The first sclk rise occurs SCLK_HALF cycles after cs_n falls.
- Unpacking: received bits pair in order, MSB-first within each byte. Entry data = {first bit, second bit}.
- Write timing:
  - write_enable goes low for exactly 1 cycle, the cycle after the second bit of a pair is sampled.
  - Address and data are stable during that cycle.
  - write_address increments on the cycle after the strobe.
- Completion:
  - The last write goes to address target-1 (511 or 2047). There is no wrap write.
  - DONE is entered the cycle after the last strobe.
- Abort:
  - If the active trigger line (the one that started the fetch) returns high before DONE, go to IDLE next cycle.
  - On abort: cs_n=1, sclk=0, no further writes, done not pulsed.
- Reset mid-operation has the same effect as abort, plus all reset values are applied.
- Throughput: a page takes (32+1024)*2*SCLK_HALF + ~4 cycles ≈ 88 us at default. This is under one bubble position period.

Decomposition:
- Shared package bubble_pkg:
  - SPI_CMD_READ=8'h03.
  - BOOT_PAGE.
  - PAGE_ENTRIES, BOOT_ENTRIES.
  - State enum {IDLE, CMD, ADDR, DATA, DONE}.
- Natural sub-module spi_shift_engine: sclk divider plus one-bit shift/sample, exposing bit_tick_rise/bit_tick_fall strobes. The FSM and buffer writer stay in spi_page_loader.

Test Plan:
- Reset, then idle 20 cycles -> cs_n=1, sclk=0, write_enable=1, busy=0 throughout.
- load_page falls with start_of_page_address=22'h0ABC80, flash model returns 0x1B,0xE4,... ->
  - MOSI stream is 0x03 then 0x0ABC80.
  - Entries 0..3 = 00,01,10,11; entries 4..7 = 11,10,01,00.
  - 512 strobes, last at address 511, one done pulse.
- load_bootloader falls with image_number=3'd5 -> address 24'h2C0280; 2048 writes, final address 2047; done pulses once.
- load_page and load_bootloader fall in the same cycle -> bootloader address used; 2048 entries written.
- load_page returns high after 100 data entries -> cs_n high within 1 cycle; no strobes beyond address 99; done never pulses; a next trigger restarts at address 0.
- reset asserted mid-ADDR -> all outputs at reset values next cycle; a subsequent load_page fetch completes normally.
